// File: rtl/frame_marker_inserter.sv
// frame_marker_inserter: serial telemetry frame former with rotating marker, FIFO payload, filler insertion and status counters
module frame_marker_inserter #(
  parameter int SYNC_W = 31,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 31'b1111100110100100001010111011000,
  parameter int SUB_W = 13,
  parameter logic [SUB_W-1:0] SUB_WORD = 13'b1111100110101,
  parameter int DATA_BITS = 2816,
  parameter int BIT_PERIOD = 8,
  parameter int FILL_TIMEOUT = 16,
  parameter logic FILL_BIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ien,
  input  logic        iemp,
  input  logic        idat,
  output logic        orack,
  output logic        odat,
  output logic        oval,
  output logic        osof,
  output logic        ofill,
  output logic [15:0] ofrm,
  output logic [15:0] ounf
);
  localparam int MW = SYNC_W + SUB_W;
  localparam int MBW = $clog2(MW);
  localparam int DW = $clog2(DATA_BITS + 1);
  localparam int CW = $clog2(BIT_PERIOD);
  localparam int TW = $clog2(FILL_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, MARK, DATA_WAIT, DATA_SLOT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cyc, cyc_nx;
  logic [MBW-1:0] mbit, mbit_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic [TW-1:0] wcnt, wcnt_nx;
  logic [1:0] vrnt, vrnt_nx;
  logic fill, fill_nx, slot_end;
  logic [MW-1:0] marker;
  logic odat_nx, oval_nx, orack_nx, osof_nx, ofill_nx;
  logic [15:0] frm_nx, unf_q, unf_nx;
  assign ounf = unf_q;
  assign marker = {SYNC_WORD ^ {SYNC_W{vrnt[0]}}, SUB_WORD ^ {SUB_W{vrnt[1]}}};
  assign slot_end = cyc == CW'(BIT_PERIOD - 1);
  always_comb begin
    state_nx = state;
    cyc_nx = slot_end ? '0 : cyc + CW'(1);
    mbit_nx = mbit;
    dcnt_nx = dcnt;
    wcnt_nx = wcnt;
    vrnt_nx = vrnt;
    fill_nx = fill;
    frm_nx = ofrm;
    unf_nx = unf_q;
    odat_nx = odat;
    oval_nx = 1'b0;
    orack_nx = 1'b0;
    osof_nx = 1'b0;
    ofill_nx = 1'b0;
    case (state)
      IDLE: begin
        cyc_nx = '0;
        state_nx = ien ? MARK : IDLE;
      end
      MARK: begin
        odat_nx = cyc == '0 ? marker[MBW'(MW - 1) - mbit] : odat;
        oval_nx = cyc == CW'(1);
        osof_nx = cyc == CW'(1) && mbit == '0;
        if (slot_end) begin
          mbit_nx = mbit == MBW'(MW - 1) ? '0 : mbit + MBW'(1);
          wcnt_nx = '0;
          state_nx = mbit == MBW'(MW - 1) ? DATA_WAIT : MARK;
        end
      end
      DATA_WAIT: begin
        cyc_nx = '0;
        if (!iemp) begin
          odat_nx = idat;
          orack_nx = 1'b1;
          fill_nx = 1'b0;
          cyc_nx = CW'(1);
          state_nx = DATA_SLOT;
        end else if (wcnt == TW'(FILL_TIMEOUT - 1)) begin
          // a FIFO that fills on the following cycle is not read: the filler slot has already begun
          fill_nx = 1'b1;
          unf_nx = unf_q + {15'd0, ~&unf_q};
          state_nx = DATA_SLOT;
        end else begin
          wcnt_nx = wcnt + TW'(1);
        end
      end
      DATA_SLOT: begin
        odat_nx = cyc == '0 ? FILL_BIT : odat;
        oval_nx = cyc == CW'(1);
        ofill_nx = cyc == CW'(1) && fill;
        if (slot_end) begin
          wcnt_nx = '0;
          dcnt_nx = dcnt == DW'(DATA_BITS - 1) ? '0 : dcnt + DW'(1);
          frm_nx = dcnt == DW'(DATA_BITS - 1) ? ofrm + 16'd1 : ofrm;
          vrnt_nx = dcnt == DW'(DATA_BITS - 1) ? vrnt + 2'd1 : vrnt;
          state_nx = dcnt != DW'(DATA_BITS - 1) ? DATA_WAIT : ien ? MARK : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cyc <= '0;
      mbit <= '0;
      dcnt <= '0;
      wcnt <= '0;
      vrnt <= '0;
      fill <= 1'b0;
      ofrm <= '0;
      unf_q <= '0;
      odat <= 1'b0;
      oval <= 1'b0;
      orack <= 1'b0;
      osof <= 1'b0;
      ofill <= 1'b0;
    end else begin
      state <= state_nx;
      cyc <= cyc_nx;
      mbit <= mbit_nx;
      dcnt <= dcnt_nx;
      wcnt <= wcnt_nx;
      vrnt <= vrnt_nx;
      fill <= fill_nx;
      ofrm <= frm_nx;
      unf_q <= unf_nx;
      odat <= odat_nx;
      oval <= oval_nx;
      orack <= orack_nx;
      osof <= osof_nx;
      ofill <= ofill_nx;
    end
  end
endmodule

// File: tb/tb_frame_marker_inserter.sv
// tb_frame_marker_inserter: table-driven phases plus corner sequences, checked every cycle against a frame-level model
module tb_frame_marker_inserter;
  localparam int SW = 31;
  localparam logic [SW-1:0] SYNC = 31'b1111100110100100001010111011000;
  localparam int SBW = 13;
  localparam logic [SBW-1:0] SUB = 13'b1111100110101;
  localparam int MW = SW + SBW;
  localparam int DB = 16;
  localparam int BP = 8;
  localparam int FT = 16;
  localparam logic FB = 1'b0;
  logic clk = 1'b0, reset = 1'b1, ien = 1'b0, iemp = 1'b0, idat = 1'b0;
  logic orack, odat, oval, osof, ofill;
  logic [15:0] ofrm, ounf;
  frame_marker_inserter #(
    .SYNC_W(SW), .SYNC_WORD(SYNC), .SUB_W(SBW), .SUB_WORD(SUB),
    .DATA_BITS(DB), .BIT_PERIOD(BP), .FILL_TIMEOUT(FT), .FILL_BIT(FB)
  ) dut (
    .clk(clk), .reset(reset), .ien(ien), .iemp(iemp), .idat(idat),
    .orack(orack), .odat(odat), .oval(oval), .osof(osof), .ofill(ofill),
    .ofrm(ofrm), .ounf(ounf)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit rnd;
    int gap;
    logic [15:0] frm;
    logic [15:0] unf;
  } vec_t;
  vec_t tbl[4];
  int n_chk = 0, n_fail = 0, n_fill = 0, n_oval = 0;
  logic e_odat = 0, e_oval = 0, e_orack = 0, e_osof = 0, e_ofill = 0;
  logic [15:0] e_frm = 0, e_unf = 0;
  int m_var = 0, m_wait_bit = -1, gap_len = 0, gap_seq = 0;
  bit ab = 0, rnd_emp = 0;
  logic s_ien, s_emp, s_dat;
  logic [MW-1:0] mk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    s_ien = ien;
    s_emp = iemp;
    s_dat = idat;
    {e_oval, e_orack, e_osof, e_ofill} = '0;
  endtask

  // one output slot; k0=2 when the slot-start cycle was already consumed by a FIFO read
  task automatic slot(input logic b, input logic sof, input logic fl, input int k0);
    for (int k = k0; k <= BP; k++) begin
      tick();
      if (ab) return;
      if (k == 1) e_odat = b;
      if (k == 2) begin
        e_oval = 1;
        e_osof = sof;
        e_ofill = fl;
      end
    end
  endtask

  task automatic frame();
    int n;
    bit got;
    mk = {(m_var % 2) ? ~SYNC : SYNC, (m_var / 2) ? ~SUB : SUB};
    for (int i = 0; i < MW; i++) begin
      slot(mk[MW-1-i], i == 0, 0, 1);
      if (ab) return;
    end
    for (int d = 0; d < DB; d++) begin
      n = 0;
      got = 0;
      m_wait_bit = d;
      while (!got && n < FT) begin
        tick();
        if (ab) return;
        if (!s_emp) begin
          got = 1;
          e_odat = s_dat;
          e_orack = 1;
        end else n++;
      end
      m_wait_bit = -1;
      if (got) slot(1'b0, 0, 0, 2);
      else begin
        if (e_unf != 16'hFFFF) e_unf++;
        slot(FB, 0, 1, 1);
      end
      if (ab) return;
    end
    e_frm++;
    m_var = (m_var + 1) % 4;
  endtask

  task automatic model_loop();
    forever begin
      do tick(); while (!(reset && s_ien));
      ab = 0;
      do frame(); while (!ab && s_ien);
    end
  endtask

  task automatic drive_loop();
    int run = 0, gap_left = 0, seen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (gap_seq != seen && m_wait_bit == 3) begin
        seen = gap_seq;
        gap_left = gap_len;
      end
      if (gap_left > 0) begin
        iemp = 1;
        gap_left--;
      end else iemp = rnd_emp && run < FT - 2 && $urandom_range(3) == 0;
      run = iemp ? run + 1 : 0;
      idat = 1'($urandom_range(1));
    end
  endtask

  task automatic check_loop();
    forever begin
      @(negedge clk);
      check("outputs", {odat, oval, orack, osof, ofill, ofrm, ounf},
            {e_odat, e_oval, e_orack, e_osof, e_ofill, e_frm, e_unf});
      if (oval) n_oval++;
      if (oval && ofill) n_fill++;
    end
  endtask

  task automatic wait_frm(input logic [15:0] t);
    int k = 0;
    while (e_frm != t && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (e_frm != t) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_frames: model count %0d required %0d", e_frm, t);
    end
    #1;
  endtask

  task automatic wait_bit(input int b);
    int k = 0;
    while (m_wait_bit != b && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (m_wait_bit != b) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_bit: model bit %0d required %0d", m_wait_bit, b);
    end
  endtask

  initial begin
    int k, n0;
    tbl[0] = '{0, 0, 16'd1, 16'd0};
    tbl[1] = '{1, 0, 16'd5, 16'd0};
    tbl[2] = '{0, 40, 16'd6, 16'd2};
    tbl[3] = '{1, 0, 16'd8, 16'd2};
    fork
      model_loop();
      drive_loop();
      check_loop();
      begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
      end
    join_none
    #1 reset = 0;
    #1 check("reset_state", {odat, oval, orack, osof, ofill, ofrm, ounf}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1;
    ien = 1;
    foreach (tbl[p]) begin
      rnd_emp = tbl[p].rnd;
      if (tbl[p].gap > 0) begin
        gap_len = tbl[p].gap;
        gap_seq++;
      end
      wait_frm(tbl[p].frm);
      check($sformatf("ofrm_phase%0d", p), ofrm, tbl[p].frm);
      check($sformatf("ounf_phase%0d", p), ounf, tbl[p].unf);
    end
    rnd_emp = 1;
    repeat (50) @(negedge clk);
    ien = 0;
    wait_frm(16'd9);
    n0 = n_oval;
    repeat (120) @(negedge clk);
    #1 check("idle_quiet", n_oval - n0, 0);
    @(posedge clk);
    #1 ien = 1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!oval && k < 20);
    check("restart_latency", k, 4);
    check("restart_sof", osof, 1);
    wait_bit(5);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 0;
    ab = 1;
    {e_odat, e_oval, e_orack, e_osof, e_ofill} = '0;
    e_frm = 0;
    e_unf = 0;
    m_var = 0;
    m_wait_bit = -1;
    #1 check("async_reset", {odat, oval, orack, osof, ofill, ofrm, ounf}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1;
    repeat (20) @(negedge clk);
    check("ofrm_after_reset", ofrm, 0);
    ien = 0;
    wait_frm(16'd1);
    check("ofrm_post_reset", ofrm, 1);
    @(posedge clk);
    #2 force dut.unf_q = 16'hFFFE;
    e_unf = 16'hFFFE;
    @(posedge clk);
    #2 release dut.unf_q;
    rnd_emp = 0;
    gap_len = 100;
    gap_seq++;
    n0 = n_fill;
    ien = 1;
    repeat (20) @(negedge clk);
    ien = 0;
    wait_frm(16'd2);
    check("fill_count", n_fill - n0, 4);
    check("ounf_sat", ounf, 16'hFFFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
